// File: rtl/dma_block_controller_pkg.sv
// Shared DMA constants, controller state encoding and the line-address helper.
package dma_pkg;

  localparam int unsigned WORD_SIZE  = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LEN_W      = 4;
  localparam int unsigned LINE_W     = WORD_SIZE * LINE_WORDS;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWrite,
    StNext,
    StRelease,
    StDone
  } dma_state_t;

  // Word address of a line relative to the block base; wraps modulo 2^WORD_SIZE.
  function automatic logic [WORD_SIZE-1:0] line_addr(logic [WORD_SIZE-1:0] base,
                                                     logic [LEN_W-1:0]     line);
    return base + WORD_SIZE'(line) * WORD_SIZE'(LINE_WORDS);
  endfunction

endpackage

// File: rtl/dma_block_controller_if.sv
// Command, bus-arbitration, device-buffer and memory-write signals of the DMA controller.
interface dma_block_controller_if;
  import dma_pkg::*;

  logic                 cmd;
  logic [WORD_SIZE-1:0] cmd_addr;
  logic [LEN_W-1:0]     cmd_lines;
  logic                 BG;
  logic                 BR;
  logic [LEN_W-1:0]     dev_line;
  logic [LINE_W-1:0]    dev_data;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [LINE_W-1:0]    mem_data;
  logic                 mem_done;
  logic                 busy;
  logic                 dma_end_int;

  modport master (
    input  cmd, cmd_addr, cmd_lines, BG, dev_data, mem_done,
    output BR, dev_line, mem_write, mem_addr, mem_data, busy, dma_end_int
  );

  modport slave (
    output cmd, cmd_addr, cmd_lines, BG, dev_data, mem_done,
    input  BR, dev_line, mem_write, mem_addr, mem_data, busy, dma_end_int
  );

endinterface

// File: rtl/dma_block_controller.sv
// Bus-master sequencer: requests the bus, copies a block of device lines into data memory
// one write handshake per line, releases the bus and pulses a completion interrupt.
module dma_block_controller
  import dma_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  dma_block_controller_if.master bus
);

  dma_state_t           state_q, state_d;
  logic                 cmd_prev_q;
  logic [WORD_SIZE-1:0] base_q, base_d;
  logic [LEN_W-1:0]     lines_q, lines_d;
  logic [LEN_W-1:0]     line_q, line_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]    mem_data_q, mem_data_d;
  logic                 br_q, busy_q, mem_write_q, end_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    lines_d    = lines_q;
    line_d     = line_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd && !cmd_prev_q) begin
          base_d  = bus.cmd_addr;
          lines_d = bus.cmd_lines;
          line_d  = '0;
          state_d = (bus.cmd_lines == '0) ? StDone : StReq;
        end
      end
      StReq: begin
        if (bus.BG) state_d = StWrite;
      end
      StWrite: begin
        // A completed handshake wins over a simultaneous grant loss.
        if (bus.mem_done) begin
          line_d  = line_q + LEN_W'(1);
          state_d = StNext;
        end else if (!bus.BG) begin
          state_d = StReq;
        end
      end
      StNext: begin
        state_d = (line_q == lines_q) ? StRelease : StWrite;
      end
      StRelease: begin
        if (!bus.BG) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // dev_line already shows line_q, so dev_data is valid for the line being entered.
    if (state_d == StWrite && state_q != StWrite) begin
      mem_addr_d = line_addr(base_q, line_q);
      mem_data_d = bus.dev_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_prev_q  <= 1'b0;
      base_q      <= '0;
      lines_q     <= '0;
      line_q      <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      br_q        <= 1'b0;
      busy_q      <= 1'b0;
      mem_write_q <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_prev_q  <= bus.cmd;
      base_q      <= base_d;
      lines_q     <= lines_d;
      line_q      <= line_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      br_q        <= (state_d == StReq) || (state_d == StWrite) || (state_d == StNext);
      busy_q      <= (state_d != StIdle);
      mem_write_q <= (state_d == StWrite);
      end_q       <= (state_d == StDone);
    end
  end

  assign bus.BR          = br_q;
  assign bus.busy        = busy_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.dev_line    = line_q;
  assign bus.dma_end_int = end_q;

endmodule
